// File: rtl/efpga_apb2lint_bridge.sv
// efpga_apb2lint_bridge: APB slave to PULP LINT master bridge for the eFPGA wrapper.
// Each APB access becomes one LINT req/gnt/valid transaction. PREADY stays low until the
// LINT response arrives, or until a bounded timeout expires and the access is failed.
module efpga_apb2lint_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned ADDR_LSB       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hBADACCE5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic [3:0]                PSTRB,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      lint_req_o,
    output logic [19:0]               lint_addr_o,
    output logic                      lint_wen_o,
    output logic [3:0]                lint_be_o,
    output logic [31:0]               lint_wdata_o,
    input  logic                      lint_gnt_i,
    input  logic                      lint_valid_i,
    input  logic [31:0]               lint_rdata_i
);

    localparam int unsigned     CntW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e          r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_inc;
    logic            r_pend;
    logic [19:0]     r_addr;
    logic            r_wen;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic w_start, w_valid, w_done, w_timeout, w_set_pend, w_unused;

    // A valid that belongs to a timed-out, already-granted request is never a real response.
    assign w_valid   = lint_valid_i & ~r_pend;
    // Saturating increment: the counter never wraps back into the legal window.
    assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + 1'b1;
    assign w_unused  = ^PADDR;

    // Next-state decode: normal completion takes priority over a timeout on the same edge.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        w_set_pend   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (PSEL && PENABLE) begin
                    w_start      = 1'b1;
                    w_state_next = StReq;
                end
            end
            StReq: begin
                if (lint_gnt_i && w_valid) begin
                    w_done       = 1'b1;
                    w_state_next = StResp;
                end else if (w_cnt_inc == CntMax) begin
                    w_timeout    = 1'b1;
                    w_set_pend   = lint_gnt_i;
                    w_state_next = StResp;
                end else if (lint_gnt_i) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (w_valid) begin
                    w_done       = 1'b1;
                    w_state_next = StResp;
                end else if (w_cnt_inc == CntMax) begin
                    w_timeout    = 1'b1;
                    w_set_pend   = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State, request capture, timeout counter, response capture and stale-response flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_addr  <= '0;
            r_wen   <= 1'b1;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_cnt   <= '0;
                r_addr  <= PADDR[ADDR_LSB +: 20];
                r_wen   <= ~PWRITE;
                r_be    <= PWRITE ? PSTRB : 4'hF;
                r_wdata <= PWDATA;
            end else if (r_state == StReq || r_state == StWait) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_done) begin
                r_err   <= 1'b0;
                r_rdata <= r_wen ? lint_rdata_i : 32'h0;
            end else if (w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= ERR_RDATA;
            end
            if (w_set_pend) begin
                r_pend <= 1'b1;
            end else if (lint_valid_i) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign PREADY       = (r_state == StResp);
    assign PSLVERR      = PREADY & r_err;
    assign PRDATA       = PREADY ? r_rdata : 32'h0;
    assign lint_req_o   = (r_state == StReq);
    assign lint_addr_o  = r_addr;
    assign lint_wen_o   = r_wen;
    assign lint_be_o    = r_be;
    assign lint_wdata_o = r_wdata;

endmodule
